// File: rtl/diff_freq_cmd_encoder.sv
// rtl/diff_freq_cmd_encoder.sv - serialises one command request into UART byte frames
//
// Purpose: accepts a parallel command request (FREQ, PERIOD, DATA, CTRL or the
// combined CHAN frame), validates it, and hands the frame bytes one at a time
// to a UART transmitter through a start/done handshake, with an optional idle
// gap between bytes and a per-byte completion timeout.
//
// Ports:
//   clk, rst_n           clock; asynchronous reset, asserted high
//   req_valid_i/ready_o  request handshake, ready only while idle
//   req_op_i             0 FREQ, 1 PERIOD, 2 DATA, 3 CTRL, 4 CHAN
//   req_chan_i           channel index (DATA/CTRL/CHAN)
//   req_word_i           32-bit pattern (FREQ/DATA/CHAN), sent LSB first
//   req_slow_i/fast_i    period bytes (PERIOD)
//   req_mode_i/en_i      channel mode and enable (CTRL/CHAN)
//   tx_start_o/data_o    one-cycle load strobe and byte for the UART
//   tx_done_tick_i       UART byte-complete pulse
//   busy_o               frame in progress
//   done_tick_o          frame fully sent
//   err_tick_o/code_o    reject or abort pulse; code 01 op, 10 chan/mode, 11 timeout

module diff_freq_cmd_encoder #(
    parameter int         OUTPUT_NUM = 16,
    parameter logic [7:0] CMD_DATA   = 8'h01,
    parameter logic [7:0] CMD_CTRL   = 8'h02,
    parameter logic [7:0] CMD_FREQ   = 8'h03,
    parameter logic [7:0] CMD_PERIOD = 8'h04,
    parameter int         GAP_CYCLES = 0,
    parameter int         TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [7:0]  req_chan_i,
    input  logic [31:0] req_word_i,
    input  logic [7:0]  req_slow_i,
    input  logic [7:0]  req_fast_i,
    input  logic [1:0]  req_mode_i,
    input  logic        req_en_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_done_tick_i,
    output logic        busy_o,
    output logic        done_tick_o,
    output logic        err_tick_o,
    output logic [1:0]  err_code_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0]  CHAN_LIM = 9'(OUTPUT_NUM);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [7:0]  chan_q;
    logic [31:0] word_q;
    logic [7:0]  slow_q;
    logic [7:0]  fast_q;
    logic [1:0]  mode_q;
    logic        en_q;
    logic [3:0]  idx_q;
    logic [3:0]  last_idx_q;
    logic [15:0] to_cnt_q;
    logic [15:0] gap_cnt_q;
    logic        tx_start_q;
    logic [7:0]  tx_data_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic [1:0]  rej_code_d;
    logic [7:0]  first_byte_d;
    logic [7:0]  cur_byte_d;
    logic [7:0]  next_byte_d;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

    // Byte idx of the frame described by the given request fields.
    // CHAN is a DATA frame (idx 0..5) followed by a CTRL frame (idx 6..8).
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  op,
        input logic [7:0]  chan,
        input logic [31:0] word,
        input logic [7:0]  slow,
        input logic [7:0]  fast,
        input logic [1:0]  mode,
        input logic        en,
        input logic [3:0]  idx
    );
        logic [7:0] b;
        logic [3:0] k;
        b = 8'h00;
        k = idx;
        case (op)
            3'd0: begin
                if (idx == 4'd0) b = CMD_FREQ;
                else             b = word_byte(word, 2'(idx - 4'd1));
            end
            3'd1: begin
                case (idx)
                    4'd0:    b = CMD_PERIOD;
                    4'd1:    b = slow;
                    default: b = fast;
                endcase
            end
            default: begin
                if (op == 3'd3 || (op == 3'd4 && idx >= 4'd6)) begin
                    if (op == 3'd4) k = idx - 4'd6;
                    case (k)
                        4'd0:    b = CMD_CTRL;
                        4'd1:    b = chan;
                        default: b = {5'h00, mode, en};
                    endcase
                end else begin
                    case (idx)
                        4'd0:    b = CMD_DATA;
                        4'd1:    b = chan;
                        default: b = word_byte(word, 2'(idx - 4'd2));
                    endcase
                end
            end
        endcase
        return b;
    endfunction

    // Index of the final byte of each frame type.
    function automatic logic [3:0] frame_last(input logic [2:0] op);
        case (op)
            3'd0:    return 4'd4;
            3'd1:    return 4'd2;
            3'd2:    return 4'd5;
            3'd4:    return 4'd8;
            default: return 4'd2;
        endcase
    endfunction

    always_comb begin
        rej_code_d = 2'b00;
        if (req_op_i > 3'd4) begin
            rej_code_d = 2'b01;
        end else if ((req_op_i >= 3'd2) && ({1'b0, req_chan_i} >= CHAN_LIM)) begin
            rej_code_d = 2'b10;
        end else if ((req_op_i == 3'd3 || req_op_i == 3'd4) && req_mode_i == 2'b11) begin
            rej_code_d = 2'b10;
        end
    end

    // Byte 0 comes straight from the inputs because the fields are being
    // captured on the same edge that issues the first start.
    assign first_byte_d = frame_byte(req_op_i, req_chan_i, req_word_i, req_slow_i,
                                     req_fast_i, req_mode_i, req_en_i, 4'd0);
    assign cur_byte_d   = frame_byte(op_q, chan_q, word_q, slow_q, fast_q, mode_q, en_q, idx_q);
    assign next_byte_d  = frame_byte(op_q, chan_q, word_q, slow_q, fast_q, mode_q, en_q,
                                     idx_q + 4'd1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 3'd0;
            chan_q     <= 8'h00;
            word_q     <= 32'h0;
            slow_q     <= 8'h00;
            fast_q     <= 8'h00;
            mode_q     <= 2'b00;
            en_q       <= 1'b0;
            idx_q      <= 4'd0;
            last_idx_q <= 4'd0;
            to_cnt_q   <= 16'd0;
            gap_cnt_q  <= 16'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_q       <= req_op_i;
                        chan_q     <= req_chan_i;
                        word_q     <= req_word_i;
                        slow_q     <= req_slow_i;
                        fast_q     <= req_fast_i;
                        mode_q     <= req_mode_i;
                        en_q       <= req_en_i;
                        idx_q      <= 4'd0;
                        last_idx_q <= frame_last(req_op_i);
                        ready_q    <= 1'b0;
                        if (rej_code_d != 2'b00) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= rej_code_d;
                        end else begin
                            state_q    <= S_START;
                            tx_start_q <= 1'b1;
                            tx_data_q  <= first_byte_d;
                            busy_q     <= 1'b1;
                            to_cnt_q   <= 16'd0;
                        end
                    end
                end
                S_START: begin
                    // Timeout counts from the start cycle itself.
                    state_q  <= S_WAIT;
                    to_cnt_q <= to_cnt_q + 16'd1;
                end
                S_WAIT: begin
                    // A done arriving on the terminal count still completes the byte.
                    if (tx_done_tick_i) begin
                        if (idx_q == last_idx_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            if (GAP_CYCLES == 0) begin
                                state_q    <= S_START;
                                tx_start_q <= 1'b1;
                                tx_data_q  <= next_byte_d;
                                to_cnt_q   <= 16'd0;
                            end else begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= 16'd0;
                            end
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q    <= S_ERR;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b11;
                        busy_q     <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                S_GAP: begin
                    // idx_q already points at the byte to send next.
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q    <= S_START;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cur_byte_d;
                        to_cnt_q   <= 16'd0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign busy_o      = busy_q;
    assign done_tick_o = done_q;
    assign err_tick_o  = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_diff_freq_cmd_encoder.sv
// tb/tb_diff_freq_cmd_encoder.sv - self-checking bench for diff_freq_cmd_encoder

module tb_diff_freq_cmd_encoder;

    localparam int GAP = 3;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = 3'd0;
    logic [7:0]  req_chan_i = 8'h00;
    logic [31:0] req_word_i = 32'h0;
    logic [7:0]  req_slow_i = 8'h00;
    logic [7:0]  req_fast_i = 8'h00;
    logic [1:0]  req_mode_i = 2'b00;
    logic        req_en_i = 1'b0;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_tick_i = 1'b0;
    logic        busy_o;
    logic        done_tick_o;
    logic        err_tick_o;
    logic [1:0]  err_code_o;

    always #5 clk = ~clk;

    diff_freq_cmd_encoder #(
        .OUTPUT_NUM (16),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_chan_i     (req_chan_i),
        .req_word_i     (req_word_i),
        .req_slow_i     (req_slow_i),
        .req_fast_i     (req_fast_i),
        .req_mode_i     (req_mode_i),
        .req_en_i       (req_en_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .tx_done_tick_i (tx_done_tick_i),
        .busy_o         (busy_o),
        .done_tick_o    (done_tick_o),
        .err_tick_o     (err_tick_o),
        .err_code_o     (err_code_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: expected byte stream plus a UART responder.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         resp_en = 1'b1;
    int         resp_lat = 2;
    bit         pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] hold_byte = 8'h00;
    int         last_done_cyc = -1;
    int         last_start_cyc = 0;
    int         exp_done_cyc = -1;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         start_cnt = 0;
    int         acc_cyc = 0;
    bit         first_pending = 1'b0;

    always @(negedge clk) begin
        tx_done_tick_i = 1'b0;
        if (rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    tx_done_tick_i = 1'b1;
                    pend = 1'b0;
                    chk("data_hold", tx_data_o, hold_byte);
                    last_done_cyc = cyc;
                    if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
                end else begin
                    pend_cnt--;
                end
            end
            if (tx_start_o) begin
                start_cnt++;
                last_start_cyc = cyc;
                got_q.push_back(tx_data_o);
                if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
                else                   chk("tx_byte", tx_data_o, exp_q.pop_front());
                if (first_pending) begin
                    chk("first_start_lat", cyc, acc_cyc);
                    first_pending = 1'b0;
                end else if (last_done_cyc >= 0) begin
                    chk("gap", cyc - last_done_cyc, GAP + 1);
                end
                hold_byte = tx_data_o;
                if (resp_en) begin
                    pend = 1'b1;
                    pend_cnt = resp_lat;
                end
            end
            if (done_tick_o) begin
                done_cnt++;
                chk("done_lat", cyc, exp_done_cyc);
                last_done_cyc = -1;
            end
            if (err_tick_o) err_cnt++;
        end
    end

    function automatic logic [1:0] model_rej(input logic [2:0] op, input logic [7:0] chan,
                                             input logic [1:0] mode);
        if (op > 3'd4) return 2'b01;
        if (op >= 3'd2 && chan >= 8'd16) return 2'b10;
        if ((op == 3'd3 || op == 3'd4) && mode == 2'b11) return 2'b10;
        return 2'b00;
    endfunction

    task automatic push_data(input logic [7:0] chan, input logic [31:0] w);
        exp_q.push_back(8'h01);
        exp_q.push_back(chan);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
    endtask

    task automatic push_ctrl(input logic [7:0] chan, input logic [1:0] mode, input logic en);
        exp_q.push_back(8'h02);
        exp_q.push_back(chan);
        exp_q.push_back({5'h00, mode, en});
    endtask

    task automatic model_frame(input logic [2:0] op, input logic [7:0] chan, input logic [31:0] w,
                               input logic [7:0] slow, input logic [7:0] fast,
                               input logic [1:0] mode, input logic en);
        case (op)
            3'd0: begin
                exp_q.push_back(8'h03);
                for (int i = 0; i < 4; i++) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
            end
            3'd1: begin
                exp_q.push_back(8'h04);
                exp_q.push_back(slow);
                exp_q.push_back(fast);
            end
            3'd2: push_data(chan, w);
            3'd3: push_ctrl(chan, mode, en);
            default: begin
                push_data(chan, w);
                push_ctrl(chan, mode, en);
            end
        endcase
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] chan, input logic [31:0] w,
                        input logic [7:0] slow, input logic [7:0] fast,
                        input logic [1:0] mode, input logic en);
        for (int i = 0; i < 50 && !req_ready_o; i++) @(negedge clk);
        chk("ready_before_req", req_ready_o, 1'b1);
        req_op_i   = op;
        req_chan_i = chan;
        req_word_i = w;
        req_slow_i = slow;
        req_fast_i = fast;
        req_mode_i = mode;
        req_en_i   = en;
        got_q.delete();
        if (model_rej(op, chan, mode) == 2'b00) begin
            model_frame(op, chan, w, slow, fast, mode, en);
            first_pending = 1'b1;
        end
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid_i = 1'b0;
    endtask

    task automatic finish_frame(input bit expect_err, input logic [1:0] code);
        bit found;
        int end_cyc;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (done_tick_o || err_tick_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("frame_end_seen", found, 1'b1);
        end_cyc = cyc;
        chk("end_is_err", err_tick_o, expect_err);
        chk("end_is_done", done_tick_o, !expect_err);
        chk("busy_at_end", busy_o, !expect_err);
        chk("ready_at_end", req_ready_o, 1'b0);
        if (expect_err) begin
            chk("err_code", err_code_o, code);
            if (code != 2'b11) chk("reject_lat", end_cyc, acc_cyc);
        end
        @(negedge clk);
        #1;
        chk("ready_after", req_ready_o, 1'b1);
        chk("busy_after", busy_o, 1'b0);
    endtask

    task automatic cmp_bytes(input string name, input logic [71:0] exp, input int n);
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk(name, got_q[i], exp[8 * (n - 1 - i) +: 8]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready_o, 1'b1);
        chk({tag, "_start"}, tx_start_o, 1'b0);
        chk({tag, "_data"}, tx_data_o, 8'h00);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_tick_o, 1'b0);
        chk({tag, "_err"}, err_tick_o, 1'b0);
        chk({tag, "_code"}, err_code_o, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int d0;
        int e0;
        bit hit;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b0;
        @(negedge clk);

        // FREQ 5555_5555
        send(3'd0, 8'h00, 32'h5555_5555, 8'h00, 8'h00, 2'b00, 1'b0);
        finish_frame(1'b0, 2'b00);
        cmp_bytes("freq_bytes", 72'h03_5555_5555, 5);

        // PERIOD slow 14, fast 05 (gap of 3 checked on every byte)
        send(3'd1, 8'h00, 32'h0, 8'h14, 8'h05, 2'b00, 1'b0);
        finish_frame(1'b0, 2'b00);
        cmp_bytes("period_bytes", 72'h04_14_05, 3);

        // CHAN with inputs scrambled mid-frame
        send(3'd4, 8'h0F, 32'h1234_5678, 8'h00, 8'h00, 2'b00, 1'b1);
        repeat (6) @(negedge clk);
        req_op_i   = 3'd0;
        req_chan_i = 8'h03;
        req_word_i = 32'hDEAD_BEEF;
        req_mode_i = 2'b10;
        req_en_i   = 1'b0;
        finish_frame(1'b0, 2'b00);
        cmp_bytes("chan_bytes", 72'h01_0F_78_56_34_12_02_0F_01, 9);

        // CTRL repeat-N, disabled; DATA on channel 0
        send(3'd3, 8'h03, 32'h0, 8'h00, 8'h00, 2'b10, 1'b0);
        finish_frame(1'b0, 2'b00);
        cmp_bytes("ctrl_bytes", 72'h02_03_04, 3);
        send(3'd2, 8'h00, 32'hA5C3_0F81, 8'h00, 8'h00, 2'b01, 1'b1);
        finish_frame(1'b0, 2'b00);
        cmp_bytes("data_bytes", 72'h01_00_81_0F_C3_A5, 6);

        // Illegal requests
        s0 = start_cnt;
        send(3'd2, 8'h10, 32'h1111_1111, 8'h00, 8'h00, 2'b00, 1'b1);
        finish_frame(1'b1, 2'b10);
        send(3'd7, 8'h00, 32'h0, 8'h00, 8'h00, 2'b00, 1'b0);
        finish_frame(1'b1, 2'b01);
        send(3'd3, 8'h02, 32'h0, 8'h00, 8'h00, 2'b11, 1'b1);
        finish_frame(1'b1, 2'b10);
        chk("illegal_no_start", start_cnt, s0);

        // Timeout: UART never completes
        resp_en = 1'b0;
        send(3'd0, 8'h00, 32'h0102_0304, 8'h00, 8'h00, 2'b00, 1'b0);
        finish_frame(1'b1, 2'b11);
        chk("timeout_lat", acc_cyc + TMO, last_start_cyc + TMO);
        chk("timeout_err_at", cyc - 1 - last_start_cyc, TMO);
        exp_q.delete();
        last_done_cyc = -1;
        resp_en = 1'b1;
        send(3'd1, 8'h00, 32'h0, 8'h20, 8'h30, 2'b00, 1'b0);
        finish_frame(1'b0, 2'b00);
        cmp_bytes("period2_bytes", 72'h04_20_30, 3);
        chk("err_code_held", err_code_o, 2'b11);

        // Reset during byte 3 of a DATA frame
        d0 = done_cnt;
        e0 = err_cnt;
        s0 = start_cnt;
        send(3'd2, 8'h05, 32'hCAFE_BABE, 8'h00, 8'h00, 2'b00, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (start_cnt == s0 + 4) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_byte3", hit, 1'b1);
        #1;
        rst_n = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        exp_q.delete();
        first_pending = 1'b0;
        last_done_cyc = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_no_done", done_cnt, d0);
        chk("reset_no_err", err_cnt, e0);
        send(3'd0, 8'h00, 32'hA1B2_C3D4, 8'h00, 8'h00, 2'b00, 1'b0);
        finish_frame(1'b0, 2'b00);
        cmp_bytes("freq_after_reset", 72'h03_D4_C3_B2_A1, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/diff_freq_cmd_encoder.md
# diff_freq_cmd_encoder

Host-side command encoder for the diff_freq_serial_out UART control protocol. It accepts one parallel command request, serializes it into the byte frame expected by the command parser, and drives a UART transmitter one byte at a time through a start/done handshake. It sits between a local controller (sequencer or CPU register bank) and the `UART` TX interface. It is the on-chip equivalent of the host that programs frequency patterns, periods and per-channel data/control.

## Interface
- `OUTPUT_NUM`, 16: number of serial channels; upper bound for legal channel indices.
- `CMD_DATA`, 8'h01: data command byte; set from user_cmd.vh.
- `CMD_CTRL`, 8'h02: control command byte; set from user_cmd.vh.
- `CMD_FREQ`, 8'h03: frequency-pattern command byte; set from user_cmd.vh.
- `CMD_PERIOD`, 8'h04: period command byte; set from user_cmd.vh.
- `GAP_CYCLES`, 0: idle clocks inserted between a byte's `tx_done_tick_i` and the next `tx_start_o`.
- `TIMEOUT`, 65535: maximum clocks to wait for `tx_done_tick_i` after a start.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  encoder idle and able to accept a request.
- `req_op_i`  in  3  0=FREQ, 1=PERIOD, 2=DATA, 3=CTRL, 4=CHAN (DATA then CTRL); 5–7 illegal.
- `req_chan_i`  in  8  channel index for DATA/CTRL/CHAN.
- `req_word_i`  in  32  frequency pattern (FREQ) or data pattern (DATA/CHAN).
- `req_slow_i`, `req_fast_i`  in  8 each  slow and fast period (PERIOD).
- `req_mode_i`  in  2  00=one-shot, 01=repeat, 10=repeat-N, 11 illegal.
- `req_en_i`  in  1  channel enable.
- `tx_start_o`  out  1  one-cycle pulse; UART TX loads `tx_data_o`.
- `tx_data_o`  out  8  byte currently being sent.
- `tx_done_tick_i`  in  1  UART TX byte-complete pulse.
- `busy_o`  out  1  a frame is in progress.
- `done_tick_o`  out  1  one-cycle pulse: frame fully sent.
- `err_tick_o`  out  1  one-cycle pulse: request rejected or frame aborted.
- `err_code_o`  out  2  01=illegal op, 10=illegal chan/mode, 11=timeout; holds until the next error.

## Operation
- Frames (bytes in order, words LSB first):
  - FREQ: CMD_FREQ, w[7:0], w[15:8], w[23:16], w[31:24] (5 bytes).
  - PERIOD: CMD_PERIOD, slow, fast (3 bytes).
  - DATA: CMD_DATA, chan, w[7:0]..w[31:24] (6 bytes).
  - CTRL: CMD_CTRL, chan, {5'h0, mode, en} (3 bytes).
  - CHAN: DATA frame followed by CTRL frame (9 bytes).
- All request fields are registered on accept; later input changes do not affect a frame in progress.
- Validation on accept:
  - op > 4 → reject with code 01.
  - chan ≥ OUTPUT_NUM (DATA/CTRL/CHAN), or mode 11 (CTRL/CHAN) → reject with code 10.
  - A rejected request pulses `err_tick_o`, emits no bytes, and leaves the block in IDLE.
- FSM:
  - IDLE: accept when `req_valid_i & req_ready_o`. Legal request → START; illegal → ERR.
  - START: `tx_start_o`=1 for one cycle with `tx_data_o`=frame[idx] → WAIT.
  - WAIT: on `tx_done_tick_i`, if last byte → DONE; else idx+1 → GAP, or → START when GAP_CYCLES=0. If the timeout counter reaches TIMEOUT → ERR (code 11).
  - GAP: count GAP_CYCLES clocks → START.
  - DONE: `done_tick_o`=1 → IDLE.
  - ERR: `err_tick_o`=1 → IDLE.
- Byte index is 4 bits and is compared against a per-op frame length of 3, 5, 6 or 9. The timeout counter is 16 bits and clears at each START.
- `tx_done_tick_i` outside WAIT is ignored.

## Timing
- Reset values: `req_ready_o`=1, `tx_start_o`=0, `tx_data_o`=0, `busy_o`=0, `done_tick_o`=0, `err_tick_o`=0, `err_code_o`=0; FSM in IDLE. Reset asserted mid-frame aborts immediately, with no done or error pulse.
- `req_ready_o`=1 only in IDLE. `busy_o`=1 in START/WAIT/GAP/DONE.
- Accept at edge N → first `tx_start_o` in cycle N+1.
- `tx_data_o` stays stable from START until the matching `tx_done_tick_i`.
- `tx_done_tick_i` at cycle M → next `tx_start_o` at cycle M+1+GAP_CYCLES.
- Last `tx_done_tick_i` at M → `done_tick_o` at M+1 → `req_ready_o`=1 at M+2.
- Rejected request accepted at N → `err_tick_o` at N+1 → `req_ready_o`=1 at N+2.
- If `tx_done_tick_i` and the timeout terminal count occur in the same cycle, the done wins.

## Test plan
- FREQ with w=32'h5555_5555, looped through the real UART at the codebase BAUD_RATE → bytes CMD_FREQ,55,55,55,55; one `done_tick_o`; the parser's frequency register reads 5555_5555.
- PERIOD slow=8'h14, fast=8'h05 → bytes CMD_PERIOD,14,05; with GAP_CYCLES=3, exactly 3 idle clocks between each `tx_done_tick_i` and the next `tx_start_o`.
- CHAN with chan=15, w=32'h1234_5678, mode=00, en=1 → CMD_DATA,0F,78,56,34,12,CMD_CTRL,0F,01; request input changes mid-frame have no effect.
- Illegal requests: chan=16, then op=7, then CTRL with mode=11 → no `tx_start_o`; `err_tick_o` with codes 10, 01, 10; `req_ready_o` high 2 cycles after each accept.
- Timeout with TIMEOUT=100 and `tx_done_tick_i` held low → `err_code_o`=11 exactly 100 clocks after `tx_start_o`; a following PERIOD request completes normally.
- Reset asserted during byte 3 of a DATA frame → all outputs return to reset values asynchronously; after release, a new FREQ frame starts from byte 0.
